// File: rtl/reg8_write_arbiter.sv
// reg8_write_arbiter: round-robin arbiter sharing one load-enabled register among N writers.
module reg8_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_wdata,
  output logic [N-1:0]   o_gnt,
  output logic           o_reg_en,
  output logic [W-1:0]   o_reg_d,
  output logic           o_busy
);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t        r_state, w_next;
  logic [PW-1:0] r_ptr, w_win, w_idx;
  logic [PW:0]   w_sum;
  logic [N-1:0]  r_gnt;
  logic [W-1:0]  r_reg_d;
  logic          w_load;
  assign w_load = (r_state == IDLE) && |i_req;
  // Scan from the highest offset down so the nearest request at or above r_ptr wins.
  always_comb begin
    w_win = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);
      if (i_req[w_idx]) w_win = w_idx;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_reg_d <= '0;
    end else begin
      r_state <= w_next;
      r_gnt   <= w_load ? N'(1) << w_win : '0;
      if (w_load) begin
        r_reg_d <= i_wdata[w_win*W +: W];
        r_ptr   <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end
  always_comb w_next = w_load ? LOAD : IDLE;
  always_comb begin
    o_gnt    = r_gnt;
    o_reg_en = r_state == LOAD;
    o_busy   = r_state == LOAD;
    o_reg_d  = r_reg_d;
  end
endmodule
